fifo_drain_serializer: RTL
==========================

// Module: fifo_drain_serializer
// PURPOSE
//  Read-side controller for the team's sync FIFO (empty/full/rdata, registered read data).
//  Pops one WIDTH-bit word at a time and shifts it out one bit per handshake on a
//  valid/ready serial stream. Sits between the FIFO and a bit-serial link or transmitter.
// PARAMETERS
//  WIDTH      4   FIFO word width; bits per serialized word
//  CNT_WIDTH  16  width of the completed-word counter
//  MSB_FIRST  0   0: shift out bit 0 first; 1: shift out bit WIDTH-1 first
// PORTS
//  clk_i         in   1          clock, all logic on posedge
//  rst_i         in   1          synchronous reset, active-high
//  enable_i      in   1          1 = allowed to start popping new words
//  fifo_empty_i  in   1          FIFO empty flag
//  fifo_wr_en_i  in   1          FIFO write enable (the FIFO ignores reads while a write is requested)
//  fifo_rdata_i  in   WIDTH      FIFO read data, valid in the cycle after a pop
//  fifo_rd_en_o  out  1          pop request to the FIFO (combinational)
//  ser_data_o    out  1          current serial bit
//  ser_valid_o   out  1          ser_data_o is valid
//  ser_last_o    out  1          current bit is the final bit of its word
//  ser_ready_i   in   1          sink accepts the bit when ser_valid_o && ser_ready_i
//  busy_o        out  1          word in flight (state != IDLE)
//  word_cnt_o    out  CNT_WIDTH  words fully transmitted since reset, wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  Reset: state=IDLE, shift reg=0, bit_cnt=0, word_cnt_o=0, ser_valid_o=0, ser_data_o=0,
//   ser_last_o=0, busy_o=0, fifo_rd_en_o=0. A reset mid-word aborts the word; its
//   remaining bits are lost, and word_cnt_o does not count it.
//  pop_ok = enable_i && !fifo_empty_i && !fifo_wr_en_i.
//  FSM IDLE / LOAD / SHIFT:
//   IDLE : fifo_rd_en_o=pop_ok; if pop_ok -> LOAD.
//   LOAD : capture fifo_rdata_i into shift reg, bit_cnt=0 -> SHIFT. fifo_rd_en_o=0.
//   SHIFT: ser_valid_o=1; ser_data_o=shreg[0] (MSB_FIRST=0) or shreg[WIDTH-1] (MSB_FIRST=1).
//          ser_last_o=(bit_cnt==WIDTH-1). On handshake: shift 1 position, bit_cnt+1.
//          On handshake of the last bit: word_cnt_o+1; fifo_rd_en_o=pop_ok in that same
//          cycle; if pop_ok -> LOAD, else -> IDLE.
//  fifo_rd_en_o is never asserted outside IDLE or the last-bit handshake cycle. It is
//   never asserted while fifo_empty_i or fifo_wr_en_i is high, so the FIFO never sees
//   an underflow read or a dropped read.
//  ser_valid_o, ser_data_o and ser_last_o stay stable while ser_valid_o && !ser_ready_i.
//  ser_ready_i is ignored outside SHIFT.
//  Throughput: back-to-back words cost WIDTH+1 cycles per word (one LOAD bubble) with
//   ser_ready_i held high.
//  Latency: pop in cycle N -> first bit valid in cycle N+2.
//  enable_i low mid-word: the current word completes; no new pop follows.
//  word_cnt_o wraps from 2^CNT_WIDTH-1 to 0 without saturation.
//  busy_o=1 in LOAD and SHIFT.
// TESTING
//  1 Reset: hold rst_i 2 cycles with fifo non-empty -> every output 0, no fifo_rd_en_o pulse.
//  2 Single word 4'hA, MSB_FIRST=0, ser_ready_i=1 -> rd_en pulse in cycle N; bits 0,1,0,1
//    in cycles N+2..N+5; ser_last_o only at N+5; word_cnt_o=1.
//  3 Backpressure: ser_ready_i low 3 cycles during bit 2 of 4'h6 -> data/valid/last held
//    stable; sink still receives 0,1,1,0.
//  4 Write collision: fifo non-empty with fifo_wr_en_i=1 for 4 cycles -> fifo_rd_en_o stays
//    0; pop happens in the first cycle fifo_wr_en_i=0.
//  5 Back-to-back 4'h3 then 4'hC, MSB_FIRST=1 -> 0,0,1,1, one idle cycle, 1,1,0,0;
//    second rd_en coincides with the first word's last-bit handshake.
//  6 Reset mid-word after 2 bits, and CNT_WIDTH=2 wrap after 4 words -> abort gives
//    word_cnt_o=0; five full words later word_cnt_o=1.

Source files
------------

// File: rtl/fifo_drain_serializer.sv
// Read-side controller for the sync FIFO: pops one word at a time and shifts it
// out one bit per valid/ready handshake on a serial stream.
module fifo_drain_serializer #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 16,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 fifo_empty_i,
    input  logic                 fifo_wr_en_i,
    input  logic [WIDTH-1:0]     fifo_rdata_i,
    output logic                 fifo_rd_en_o,
    output logic                 ser_data_o,
    output logic                 ser_valid_o,
    output logic                 ser_last_o,
    input  logic                 ser_ready_i,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] word_cnt_o
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     shreg_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [CNT_WIDTH-1:0] word_cnt_q;
    logic                 pop_ok;
    logic                 hs;
    logic                 last_bit;

    // The FIFO drops reads issued alongside a write, so a write request blocks the pop.
    assign pop_ok   = enable_i && !fifo_empty_i && !fifo_wr_en_i;
    assign last_bit = (bit_cnt_q == BW'(WIDTH - 1));

    always_comb begin
        state_d      = state_q;
        fifo_rd_en_o = 1'b0;
        ser_valid_o  = 1'b0;
        ser_last_o   = 1'b0;
        hs           = 1'b0;
        case (state_q)
            IDLE: begin
                fifo_rd_en_o = pop_ok;
                if (pop_ok) state_d = LOAD;
            end
            LOAD: state_d = SHIFT;
            SHIFT: begin
                ser_valid_o = 1'b1;
                ser_last_o  = last_bit;
                hs          = ser_ready_i;
                if (hs && last_bit) begin
                    fifo_rd_en_o = pop_ok;
                    state_d      = pop_ok ? LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The pop request is combinational from FIFO flags; keep it quiet during reset.
        if (rst_i) fifo_rd_en_o = 1'b0;
    end

    assign ser_data_o = ser_valid_o && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
    assign busy_o     = (state_q != IDLE);
    assign word_cnt_o = word_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == LOAD) begin
                shreg_q   <= fifo_rdata_i;
                bit_cnt_q <= '0;
            end else if (hs) begin
                shreg_q   <= MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                bit_cnt_q <= last_bit ? '0 : bit_cnt_q + BW'(1);
                if (last_bit) word_cnt_q <= word_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

endmodule
